// File: rtl/fixed_to_float.sv
// fixed_to_float
//   Converts a signed Q2.30 fixed-point value into an IEEE-754 single-precision
//   float. The conversion is sequential: the magnitude is normalised one bit
//   per cycle, and is then rounded to nearest with ties to even.
//
// Ports
//   clk     in   1  clock; all state changes on its rising edge
//   reset   in   1  synchronous active-high reset; overrides clk_en and start
//   clk_en  in   1  clock enable; when low, all state and outputs hold
//   start   in   1  request; dataa is captured only while idle
//   dataa   in  32  signed two's-complement, 30 fractional bits
//   done    out  1  one-cycle pulse marking result valid; stretched while clk_en is low
//   result  out 32  float equivalent of the captured dataa; holds between pulses
module fixed_to_float (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_en,
   input  logic        start,
   input  logic [31:0] dataa,
   output logic        done,
   output logic [31:0] result
);

   typedef enum logic [1:0] {
      IDLE,
      NORM,
      ROUND
   } state_t;

   state_t      state_q;
   logic        sign_q;
   logic [31:0] mag_q;
   logic [7:0]  exp_q;
   logic        done_q;
   logic [31:0] result_q;

   logic [31:0] abs_data;
   logic [23:0] mant_inc;
   logic        round_up;
   logic        carry;
   logic [22:0] mant_d;
   logic [7:0]  exp_d;

   // 0x80000000 negates onto itself, which is exactly the 2.0 magnitude wanted.
   always_comb begin
      abs_data = dataa[31] ? (~dataa + 32'd1) : dataa;
   end

   // Round to nearest, ties to even: mag[8] is the mantissa LSB, mag[7] the
   // guard bit, and mag[6:0] feed the sticky bit.
   always_comb begin
      mant_inc = {1'b0, mag_q[30:8]} + 24'd1;
      round_up = mag_q[7] & ((|mag_q[6:0]) | mag_q[8]);
      carry    = round_up & mant_inc[23];
      mant_d   = round_up ? mant_inc[22:0] : mag_q[30:8];
      exp_d    = exp_q + {7'd0, carry};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         sign_q   <= 1'b0;
         mag_q    <= '0;
         exp_q    <= '0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else if (clk_en) begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  sign_q  <= dataa[31];
                  mag_q   <= abs_data;
                  exp_q   <= 8'd128;
                  state_q <= NORM;
               end
            end
            NORM: begin
               if (mag_q[31] || (mag_q == '0)) begin
                  state_q <= ROUND;
               end else begin
                  mag_q <= {mag_q[30:0], 1'b0};
                  exp_q <= exp_q - 8'd1;
               end
            end
            ROUND: begin
               // A zero magnitude never normalises; emit positive zero directly.
               result_q <= (mag_q == '0) ? '0 : {sign_q, exp_d, mant_d};
               done_q   <= 1'b1;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_fixed_to_float.sv
module tb_fixed_to_float;

   logic        clk;
   logic        reset;
   logic        clk_en;
   logic        start;
   logic [31:0] dataa;
   logic        done;
   logic [31:0] result;

   int n_tests;
   int n_fail;

   fixed_to_float dut (
      .clk    (clk),
      .reset  (reset),
      .clk_en (clk_en),
      .start  (start),
      .dataa  (dataa),
      .done   (done),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Issues one conversion and measures the posedges from acceptance to done.
   // busy_at: cycle index at which start is re-asserted while busy (-1 = never).
   // stall_at: cycle index at which clk_en drops for 3 cycles (-1 = never).
   // chk_pulse: verify done falls after one cycle (off when chaining back-to-back).
   task automatic run_conv(input string tag, input logic [31:0] d, input logic [31:0] exp_res,
                           input int exp_lat, input int busy_at, input int stall_at,
                           input bit chk_pulse);
      int n;
      bit seen;
      @(negedge clk);
      dataa = d;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      dataa = 32'hDEAD_BEEF;
      n = 0;
      seen = 1'b0;
      while (n < 60 && !seen) begin
         if (done) begin
            seen = 1'b1;
         end else begin
            if (n == busy_at) begin
               start = 1'b1;
               dataa = 32'h4000_0000;
            end else begin
               start = 1'b0;
            end
            clk_en = !(stall_at >= 0 && n >= stall_at && n < stall_at + 3);
            @(posedge clk);
            #1;
            n++;
         end
      end
      start  = 1'b0;
      clk_en = 1'b1;
      check({tag, "_seen"}, {31'd0, seen}, 32'd1);
      check({tag, "_lat"}, n, exp_lat);
      check({tag, "_res"}, result, exp_res);
      if (chk_pulse && seen) begin
         @(posedge clk);
         #1;
         check({tag, "_pulse"}, {31'd0, done}, 32'd0);
         check({tag, "_hold"}, result, exp_res);
      end
   endtask

   initial begin
      int highs;
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b1;
      clk_en  = 1'b0;
      start   = 1'b1;
      dataa   = 32'h4000_0000;
      repeat (2) @(posedge clk);
      #1;
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_result", result, 32'h0000_0000);
      reset  = 1'b0;
      start  = 1'b0;
      clk_en = 1'b1;

      run_conv("one",      32'h4000_0000, 32'h3F80_0000,  3, -1, -1, 1'b1);
      run_conv("neg_one",  32'hC000_0000, 32'hBF80_0000,  3, -1, -1, 1'b1);
      run_conv("half",     32'h2000_0000, 32'h3F00_0000,  4, -1, -1, 1'b1);
      run_conv("tiny",     32'h0000_0001, 32'h3080_0000, 33, -1, -1, 1'b1);
      run_conv("zero",     32'h0000_0000, 32'h0000_0000,  2, -1, -1, 1'b1);
      run_conv("neg_two",  32'h8000_0000, 32'hC000_0000,  2, -1, -1, 1'b1);
      run_conv("max_pos",  32'h7FFF_FFFF, 32'h4000_0000,  3, -1, -1, 1'b1);
      run_conv("tie_even", 32'h4000_0040, 32'h3F80_0000,  3, -1, -1, 1'b1);
      run_conv("tie_odd",  32'h4000_00C0, 32'h3F80_0002,  3, -1, -1, 1'b1);
      run_conv("neg_frac", 32'hF000_0000, 32'hBE80_0000,  5, -1, -1, 1'b1);

      // Back-to-back: the second start lands in the done cycle of the first.
      run_conv("b2b_a", 32'h2000_0000, 32'h3F00_0000, 4, -1, -1, 1'b0);
      run_conv("b2b_b", 32'hC000_0000, 32'hBF80_0000, 3, -1, -1, 1'b1);

      // Busy start ignored and a 3-cycle clk_en gap mid-NORM.
      run_conv("busy_stall", 32'h0000_0001, 32'h3080_0000, 36, 3, 10, 1'b1);

      // Reset during NORM aborts the conversion.
      @(negedge clk);
      dataa = 32'h0000_0001;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      highs = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) highs++;
         @(posedge clk);
         #1;
      end
      check("abort_no_done", highs, 32'd0);
      check("abort_result", result, 32'h0000_0000);
      run_conv("after_abort", 32'h4000_0000, 32'h3F80_0000, 3, -1, -1, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
